id_stage_pipe: RTL

Registered, parametrised decode stage between instruction fetch and execute. It decodes one instruction per cycle into an ID/EX holding register with a valid/ready handshake. It detects load-use hazards and inserts a bubble. It tracks the slot after a branch/jump, either marking it as a delay-slot instruction or squashing it to a NOP.

---
 rtl/isa_pkg.sv | 50 +++++
 rtl/id_decode.sv | 96 +++++++++
 rtl/id_stage_pipe.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the decode path.
// Opcodes, functs, branch/ALU encodings and the control bundle.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;
    localparam logic [1:0] BR_J    = 2'd3;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_imm;
        logic       reg_dst_rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] branch_type;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef enum logic {
        S_IDLE,
        S_SLOT
    } slot_state_t;

endpackage

// File: rtl/id_decode.sv
// Combinational instruction field decoder.
// Produces controls, extended immediate and source-use flags.
module id_decode
    import isa_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [15:0]     imm16,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm_ext,
    output logic            uses_rs,
    output logic            uses_rt
);

    logic zero_ext;

    // Opcode/funct to control bundle; unknown encodings fall to NOP.
    always_comb begin
        ctrl     = CTRL_NOP;
        zero_ext = 1'b0;
        uses_rs  = 1'b0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: ctrl.alu_op = ALU_ADD;
                    FN_SUB: ctrl.alu_op = ALU_SUB;
                    FN_AND: ctrl.alu_op = ALU_AND;
                    FN_OR:  ctrl.alu_op = ALU_OR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
                if (funct == FN_ADD || funct == FN_SUB ||
                    funct == FN_AND || funct == FN_OR) begin
                    ctrl.reg_dst_rd = 1'b1;
                    ctrl.reg_write  = 1'b1;
                    uses_rs         = 1'b1;
                    uses_rt         = 1'b1;
                end
            end
            OP_ADDI: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                uses_rs          = 1'b1;
            end
            OP_ANDI: begin
                ctrl.alu_op      = ALU_AND;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                zero_ext         = 1'b1;
                uses_rs          = 1'b1;
            end
            OP_ORI: begin
                ctrl.alu_op      = ALU_OR;
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                zero_ext         = 1'b1;
                uses_rs          = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.mem_read    = 1'b1;
                ctrl.mem_to_reg  = 1'b1;
                uses_rs          = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src_imm = 1'b1;
                ctrl.mem_write   = 1'b1;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op      = ALU_SUB;
                ctrl.branch_type = BR_BEQ;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_BNE: begin
                ctrl.alu_op      = ALU_SUB;
                ctrl.branch_type = BR_BNE;
                uses_rs          = 1'b1;
                uses_rt          = 1'b1;
            end
            OP_J: begin
                ctrl.branch_type = BR_J;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

    assign imm_ext = zero_ext ? {{(XLEN-16){1'b0}}, imm16}
                              : {{(XLEN-16){imm16[15]}}, imm16};

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: ID/EX holding register, load-use
// bubble insertion, branch-slot tracking and stall counter.
module id_stage_pipe
    import isa_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit DELAY_SLOT  = 1'b1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [31:0]            if_instr,
    input  logic [XLEN-1:0]        if_pc_plus4,
    output logic                   if_ready,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   id_valid,
    output logic [4:0]             id_rs_addr,
    output logic [4:0]             id_rt_addr,
    output logic [4:0]             id_rd_addr,
    output logic [3:0]             id_alu_op,
    output logic                   id_alu_src_imm,
    output logic                   id_reg_dst_rd,
    output logic                   id_reg_write,
    output logic                   id_mem_read,
    output logic                   id_mem_write,
    output logic                   id_mem_to_reg,
    output logic [1:0]             id_branch_type,
    output logic [XLEN-1:0]        id_imm_ext,
    output logic [25:0]            id_jump_index,
    output logic [XLEN-1:0]        id_pc_plus4,
    output logic                   id_in_slot,
    output logic                   id_squashed,
    output logic [STALL_CNT_W-1:0] stall_count
);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_q;
    ctrl_t            load_ctrl;
    logic [XLEN-1:0]  dec_imm;
    logic             uses_rs;
    logic             uses_rt;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic             hazard;
    logic             accept;
    logic             in_slot_d;
    logic             is_branch;
    slot_state_t      state_q;
    slot_state_t      state_d;

    localparam logic [STALL_CNT_W-1:0] CNT_ONE =
        {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    assign in_rs = if_instr[25:21];
    assign in_rt = if_instr[20:16];

    id_decode #(.XLEN(XLEN)) u_dec (
        .opcode  (if_instr[31:26]),
        .funct   (if_instr[5:0]),
        .imm16   (if_instr[15:0]),
        .ctrl    (dec_ctrl),
        .imm_ext (dec_imm),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt)
    );

    assign hazard = if_valid && id_valid && ctrl_q.mem_read &&
                    (id_rt_addr != 5'd0) &&
                    ((uses_rs && in_rs == id_rt_addr) ||
                     (uses_rt && in_rt == id_rt_addr));

    assign if_ready  = !flush && (!id_valid || ex_ready) && !hazard;
    assign accept    = if_valid && if_ready;
    assign is_branch = dec_ctrl.branch_type != BR_NONE;
    assign in_slot_d = state_q == S_SLOT;

    // Slot squash keeps register fields and PC but drops all controls.
    assign load_ctrl = (in_slot_d && !DELAY_SLOT) ? CTRL_NOP : dec_ctrl;

    // Slot FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Slot FSM next state: arm on accepted branch, clear on next accept.
    always_comb begin
        state_d = state_q;
        if (flush)
            state_d = S_IDLE;
        else if (accept && is_branch)
            state_d = S_SLOT;
        else if (accept)
            state_d = S_IDLE;
    end

    // ID/EX holding register and load-use stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid      <= 1'b0;
            ctrl_q        <= CTRL_NOP;
            id_rs_addr    <= '0;
            id_rt_addr    <= '0;
            id_rd_addr    <= '0;
            id_imm_ext    <= '0;
            id_jump_index <= '0;
            id_pc_plus4   <= '0;
            id_in_slot    <= 1'b0;
            id_squashed   <= 1'b0;
            stall_count   <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (hazard) begin
            if (ex_ready) begin
                id_valid <= 1'b0;
                if (stall_count != '1)
                    stall_count <= stall_count + CNT_ONE;
            end
        end else if (accept) begin
            id_valid      <= 1'b1;
            ctrl_q        <= load_ctrl;
            id_rs_addr    <= in_rs;
            id_rt_addr    <= in_rt;
            id_rd_addr    <= if_instr[15:11];
            id_imm_ext    <= dec_imm;
            id_jump_index <= if_instr[25:0];
            id_pc_plus4   <= if_pc_plus4;
            id_in_slot    <= in_slot_d;
            id_squashed   <= in_slot_d && !DELAY_SLOT;
        end else if (ex_ready) begin
            id_valid <= 1'b0;
        end
    end

    assign id_alu_op      = ctrl_q.alu_op;
    assign id_alu_src_imm = ctrl_q.alu_src_imm;
    assign id_reg_dst_rd  = ctrl_q.reg_dst_rd;
    assign id_reg_write   = ctrl_q.reg_write;
    assign id_mem_read    = ctrl_q.mem_read;
    assign id_mem_write   = ctrl_q.mem_write;
    assign id_mem_to_reg  = ctrl_q.mem_to_reg;
    assign id_branch_type = ctrl_q.branch_type;

endmodule
